// File: rtl/gppcu_stall_gen_pkg.sv
// Shared types for the GPPCU register scoreboard: register index width and hazard terms.
package gppcu_stall_gen_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int MAX_NUMREG = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic raw_a;
        logic raw_b;
        logic waw;
    } hazard_t;

    function automatic logic any_hazard(input hazard_t h);
        return h.raw_a | h.raw_b | h.waw;
    endfunction

endpackage

// File: rtl/gppcu_stall_gen.sv
// Register scoreboard gating issue of the decode-stage instruction on RAW/WAW hazards.
// Define GPPCU_STALL_WB_BYPASS_EN to treat a register retiring this cycle as already free.
module gppcu_stall_gen
    import gppcu_stall_gen_pkg::*;
#(
    parameter int NUMREG = 32
) (
    input  logic              iACLK,
    input  logic              inRST,
    input  reg_idx_t          iREGD,
    input  reg_idx_t          iREGA,
    input  reg_idx_t          iREGB,
    input  logic              iVALID_REGD,
    input  logic              iVALID_REGA,
    input  logic              iVALID_REGB,
    input  reg_idx_t          iWRREG,
    input  logic              iWRREG_VALID,
    output logic              oENABLED,
    output logic [NUMREG-1:0] oPENDING
);

    logic [NUMREG-1:0] pending;
    logic [NUMREG-1:0] busy;
    logic [NUMREG-1:0] sel_a;
    logic [NUMREG-1:0] sel_b;
    logic [NUMREG-1:0] sel_d;
    logic [NUMREG-1:0] retire_hit;
    hazard_t           hz;
    logic              enabled;

    // Indices at or above NUMREG never match a decoder bit, so they are never busy.
    for (genvar i = 0; i < NUMREG; i++) begin : g_reg
        assign sel_a[i]      = (iREGA == REG_IDX_W'(i));
        assign sel_b[i]      = (iREGB == REG_IDX_W'(i));
        assign sel_d[i]      = (iREGD == REG_IDX_W'(i));
        assign retire_hit[i] = iWRREG_VALID && (iWRREG == REG_IDX_W'(i));

        // Set has priority over clear so a fresh reservation survives its own retire.
        always_ff @(posedge iACLK) begin
            if (!inRST) begin
                pending[i] <= 1'b0;
            end else if (enabled && iVALID_REGD && sel_d[i]) begin
                pending[i] <= 1'b1;
            end else if (retire_hit[i]) begin
                pending[i] <= 1'b0;
            end
        end
    end

`ifdef GPPCU_STALL_WB_BYPASS_EN
    assign busy = pending & ~retire_hit;
`else
    assign busy = pending;
`endif

    always_comb begin
        hz       = '0;
        hz.raw_a = iVALID_REGA & (|(busy & sel_a));
        hz.raw_b = iVALID_REGB & (|(busy & sel_b));
        hz.waw   = iVALID_REGD & (|(busy & sel_d));
    end

    assign enabled  = inRST & ~any_hazard(hz);
    assign oENABLED = enabled;
    assign oPENDING = pending;

endmodule

// File: tb/tb_gppcu_stall_gen.sv
// Randomized and directed bench for gppcu_stall_gen at NUMREG=32 and NUMREG=8,
// checked against a per-register reservation model.
module tb_gppcu_stall_gen;

    logic       clk;
    logic       rstN;
    logic [4:0] regD, regA, regB, wrReg;
    logic       vD, vA, vB, wrV;
    logic        en32, en8;
    logic [31:0] pend32;
    logic [7:0]  pend8;

    int assertCount = 0;
    int failCount   = 0;

    bit [31:0] model32;
    bit [31:0] model8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gppcu_stall_gen #(.NUMREG(32)) dut32 (
        .iACLK(clk), .inRST(rstN),
        .iREGD(regD), .iREGA(regA), .iREGB(regB),
        .iVALID_REGD(vD), .iVALID_REGA(vA), .iVALID_REGB(vB),
        .iWRREG(wrReg), .iWRREG_VALID(wrV),
        .oENABLED(en32), .oPENDING(pend32)
    );

    gppcu_stall_gen #(.NUMREG(8)) dut8 (
        .iACLK(clk), .inRST(rstN),
        .iREGD(regD), .iREGA(regA), .iREGB(regB),
        .iVALID_REGD(vD), .iVALID_REGA(vA), .iVALID_REGB(vB),
        .iWRREG(wrReg), .iWRREG_VALID(wrV),
        .oENABLED(en8), .oPENDING(pend8)
    );

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // A register is busy if it holds an outstanding write it can't yet hand over.
    function automatic bit modelBusy(input bit [31:0] p, input int n, input logic [4:0] r);
        bit b;
        if (int'(r) >= n) return 1'b0;
        b = p[r];
`ifdef GPPCU_STALL_WB_BYPASS_EN
        if (wrV && wrReg == r) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic bit modelEnabled(input bit [31:0] p, input int n);
        bit hazard;
        hazard = (vA && modelBusy(p, n, regA)) || (vB && modelBusy(p, n, regB)) ||
                 (vD && modelBusy(p, n, regD));
        return rstN && !hazard;
    endfunction

    function automatic bit [31:0] modelNext(input bit [31:0] p, input int n);
        bit [31:0] q;
        bit        canIssue;
        if (!rstN) return '0;
        canIssue = modelEnabled(p, n);
        q = p;
        if (wrV && int'(wrReg) < n) q[wrReg] = 1'b0;
        if (canIssue && vD && int'(regD) < n) q[regD] = 1'b1;
        return q;
    endfunction

    // Drive one cycle of inputs, check the combinational enable, then the registered vector.
    task automatic applyStimulus(input logic r, input logic [4:0] d, input logic dv,
                                 input logic [4:0] a, input logic av,
                                 input logic [4:0] b, input logic bv,
                                 input logic [4:0] w, input logic wv);
        bit [31:0] next32, next8;
        @(negedge clk);
        rstN = r; regD = d; vD = dv; regA = a; vA = av; regB = b; vB = bv;
        wrReg = w; wrV = wv;
        #1;
        checkOutput("enabled32", {31'b0, en32}, {31'b0, modelEnabled(model32, 32)});
        checkOutput("enabled8",  {31'b0, en8},  {31'b0, modelEnabled(model8, 8)});
        next32 = modelNext(model32, 32);
        next8  = modelNext(model8, 8);
        @(posedge clk);
        #1;
        model32 = next32;
        model8  = next8;
        checkOutput("pending32", pend32, model32);
        checkOutput("pending8",  {24'b0, pend8}, model8);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        rstN = 1'b0; regD = '0; regA = '0; regB = '0; wrReg = '0;
        vD = 1'b0; vA = 1'b0; vB = 1'b0; wrV = 1'b0;
        model32 = '0;
        model8  = '0;

        // Reset held two edges with random activity on the inputs.
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 5'($urandom_range(0, 31)), 1'b1, 5'($urandom_range(0, 31)), 1'b1,
                          5'($urandom_range(0, 31)), 1'b1, 5'($urandom_range(0, 31)), 1'b1);
        checkOutput("resetPending32", pend32, 32'h0);
        idle();
        checkOutput("postResetEnabled", {31'b0, en32}, 32'h1);

        // Issue r2, then RAW on source A until r2 retires.
        applyStimulus(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("issueR2", pend32, 32'h4);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);

        // WAW on r5: stalls until retire, then the reissue reserves r5 again.
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("wawReissue", {31'b0, pend32[5]}, 32'h1);

        // Set/clear collision on r3.
        applyStimulus(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);

        // Invalid source flag ignored on pending r1.
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 5'd1, 1'b0, 5'd0, 1'b0);
        checkOutput("invalidFlagEnabled", {31'b0, en32}, 32'h1);

        // Out-of-range index and a retire of a non-pending register for the 8-entry instance.
        applyStimulus(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);

        // Mid-operation reset discards reservations; a later retire is a no-op.
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        checkOutput("midReset", pend32, 32'h0);

        // Random traffic over a small index window so hazards and collisions are frequent.
        for (int i = 0; i < 600; i++)
            applyStimulus(1'($urandom_range(0, 39) != 0),
                          5'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
